// File: rtl/rst_tick_sequencer.sv
// Staged reset release for NUM_CH channels, then a per-channel divided tick.
// Ports: clk, reset (async, low), sw_rst, div_val -> rst_out, tick, busy,
//        ready; tick_cnt is added when RST_TICK_CNT_EN is defined.
module rst_tick_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sw_rst,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic [NUM_CH-1:0]       rst_out,
  output logic [NUM_CH-1:0]       tick,
`ifdef RST_TICK_CNT_EN
  output logic [NUM_CH*16-1:0]    tick_cnt,
`endif
  output logic                    busy,
  output logic                    ready
);

  localparam int HW = (HOLD_CYCLES > 1) ?
                      $clog2(HOLD_CYCLES) : 1;
  localparam int CW = (STAGGER > 0) ?
                      $clog2(STAGGER + 1) : 1;
  localparam int IW = (NUM_CH > 1) ?
                      $clog2(NUM_CH) : 1;

  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_V = CW'(STAGGER);
  localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HW-1:0]     hold_cnt;
  logic [HW-1:0]     hold_nxt;
  logic [CW-1:0]     rel_cnt;
  logic [CW-1:0]     rel_cnt_nxt;
  logic [IW-1:0]     rel_idx;
  logic [IW-1:0]     rel_idx_nxt;
  logic [NUM_CH-1:0] rst_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HOLD;
      hold_cnt <= '0;
      rel_cnt  <= '0;
      rel_idx  <= '0;
      rst_out  <= '1;
      busy     <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      rel_cnt  <= rel_cnt_nxt;
      rel_idx  <= rel_idx_nxt;
      rst_out  <= rst_nxt;
      busy     <= (state_nxt != RUN);
      ready    <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    rel_cnt_nxt = rel_cnt;
    rel_idx_nxt = rel_idx;
    rst_nxt     = rst_out;
    if (sw_rst) begin
      state_nxt   = HOLD;
      hold_nxt    = '0;
      rel_cnt_nxt = '0;
      rel_idx_nxt = '0;
      rst_nxt     = '1;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt   = RELEASE;
            hold_nxt    = '0;
            rel_cnt_nxt = '0;
            rel_idx_nxt = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (STAGGER == 0) begin
            rst_nxt   = '0;
            state_nxt = RUN;
          end else if (rel_cnt == STAG_V) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (IW'(i) == rel_idx) begin
                rst_nxt[i] = 1'b0;
              end
            end
            rel_cnt_nxt = '0;
            if (rel_idx == LAST_CH) begin
              state_nxt = RUN;
            end else begin
              rel_idx_nxt = rel_idx + 1'b1;
            end
          end else begin
            rel_cnt_nxt = rel_cnt + 1'b1;
          end
        end
        RUN: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt = HOLD;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] dv;
    logic             hit;

    assign dv  = div_val[g*DIV_W +: DIV_W];
    // >= rather than == so a lowered divide wraps at once
    assign hit = (div_cnt >= dv);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        div_cnt <= '0;
        tick[g] <= 1'b0;
      end else if (sw_rst || rst_out[g]) begin
        div_cnt <= '0;
        tick[g] <= 1'b0;
      end else if (hit) begin
        div_cnt <= '0;
        tick[g] <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        tick[g] <= 1'b0;
      end
    end

`ifdef RST_TICK_CNT_EN
    logic [15:0] tc;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        tc <= '0;
      end else if (sw_rst || rst_out[g]) begin
        tc <= '0;
      end else if (hit && tc != 16'hFFFF) begin
        tc <= tc + 16'd1;
      end
    end

    assign tick_cnt[g*16 +: 16] = tc;
`endif
  end

endmodule

// File: tb/tb_rst_tick_sequencer.sv
// Scoreboard bench for rst_tick_sequencer: staged release, ticks,
// sw_rst replay, async reset mid-release, div change, STAGGER=0.
module tb_rst_tick_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sw_rst;
  logic [31:0] div_val;
  logic [3:0]  rst_out;
  logic [3:0]  tick;
  logic        busy;
  logic        ready;
  logic [3:0]  rst_s0;
  logic [3:0]  tick_s0;
  logic        busy_s0;
  logic        ready_s0;
`ifdef RST_TICK_CNT_EN
  logic [63:0] tick_cnt;
  logic [63:0] tick_cnt_s0;
`endif

  always #5 clk = ~clk;

  rst_tick_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .sw_rst   (sw_rst),
    .div_val  (div_val),
    .rst_out  (rst_out),
    .tick     (tick),
`ifdef RST_TICK_CNT_EN
    .tick_cnt (tick_cnt),
`endif
    .busy     (busy),
    .ready    (ready)
  );

  rst_tick_sequencer #(.STAGGER(0)) dut_s0 (
    .clk      (clk),
    .reset    (reset),
    .sw_rst   (sw_rst),
    .div_val  (div_val),
    .rst_out  (rst_s0),
    .tick     (tick_s0),
`ifdef RST_TICK_CNT_EN
    .tick_cnt (tick_cnt_s0),
`endif
    .busy     (busy_s0),
    .ready    (ready_s0)
  );

  typedef struct {
    int         at;
    int         sel;
    int         ch;
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   dv[4];
  int   b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic push(input int at, input int sel,
                      input int ch, input logic [3:0] exp,
                      input string tag);
    exp_t e;
    e.at  = at;
    e.sel = sel;
    e.ch  = ch;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] act_of(input int sel,
                                        input int ch);
    case (sel)
      0: return rst_out;
      1: return {3'b0, tick[2'(ch)]};
      2: return {3'b0, busy};
      3: return {3'b0, ready};
      4: return rst_s0;
      5: return {3'b0, ready_s0};
      6: return {3'b0, tick_s0[2'(ch)]};
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic tick_due(input int k,
                                    input int r,
                                    input int d);
    return (k > r) && (((k - r) % (d + 1)) == 0);
  endfunction

  // k = -1 is the cycle right after the reset/sw_rst edge,
  // k = 0 the first edge with the sequence running.
  task automatic push_seq(input int base, input int kmax,
                          input int t0max);
    int         at;
    logic [3:0] r;
    for (int k = -1; k <= kmax; k++) begin
      at = base + k;
      r  = 4'hF;
      for (int i = 0; i < 4; i++)
        if (k >= 6 + 3 * i) r[i] = 1'b0;
      push(at, 0, 0, r, "rst_out");
      push(at, 2, 0, {3'b0, k < 15}, "busy");
      push(at, 3, 0, {3'b0, k >= 15}, "ready");
      push(at, 4, 0, (k >= 4) ? 4'h0 : 4'hF, "rst_s0");
      push(at, 5, 0, {3'b0, k >= 4}, "ready_s0");
      for (int i = 0; i < 4; i++) begin
        if (i != 0 || k <= t0max) begin
          push(at, 1, i,
               {3'b0, tick_due(k, 6 + 3 * i, dv[i])},
               $sformatf("tick%0d", i));
          push(at, 6, i,
               {3'b0, tick_due(k, 4, dv[i])},
               $sformatf("tick_s0_%0d", i));
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #3;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].at == cyc) begin
        check($sformatf("%s@%0d", sb[j].tag, sb[j].at),
              {12'h0, act_of(sb[j].sel, sb[j].ch)},
              {12'h0, sb[j].exp});
        sb.delete(j);
      end
    end
  end

  task automatic set_div();
    for (int i = 0; i < 4; i++)
      div_val[i*8 +: 8] = 8'(dv[i]);
  endtask

  task automatic run_reset(input int kmax, input int t0max,
                           output int base);
    int c;
    reset = 1'b0;
    #1;
    check("rst_now", {12'h0, rst_out}, 16'hF);
    check("tick_now", {12'h0, tick}, 16'h0);
    check("busy_now", {15'h0, busy}, 16'h1);
    check("ready_now", {15'h0, ready}, 16'h0);
    c    = cyc;
    base = c + 2;
    push_seq(base, kmax, t0max);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_swrst(input int kmax, input int t0max,
                           output int base);
    int c;
    c      = cyc;
    sw_rst = 1'b1;
    base   = c + 2;
    push_seq(base, kmax, t0max);
    @(negedge clk);
    sw_rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    sw_rst = 1'b0;
    dv     = '{0, 1, 2, 3};
    set_div();
    #1 reset = 1'b0;
    @(negedge clk);

    run_reset(30, 30, b);
    repeat (32) @(negedge clk);

    run_swrst(10, 30, b);
    repeat (11) @(negedge clk);
    run_reset(30, 30, b);
    repeat (32) @(negedge clk);

    dv[0] = 9;
    set_div();
    run_swrst(30, 12, b);
    repeat (13) @(negedge clk);
    dv[0] = 3;
    set_div();
    for (int k = 13; k <= 30; k++) begin
      push(b + k, 1, 0, {3'b0, ((k - 13) % 4) == 0},
           "tick0_chg");
      push(b + k, 6, 0, {3'b0, ((k - 13) % 4) == 0},
           "tick_s0_0_chg");
    end
    repeat (20) @(negedge clk);

`ifdef RST_TICK_CNT_EN
    dv[0] = 0;
    set_div();
    repeat (70000) @(negedge clk);
    check("tcnt_sat", tick_cnt[15:0], 16'hFFFF);
    check("tcnt_sat_s0", tick_cnt_s0[15:0], 16'hFFFF);
    run_swrst(-1, -1, b);
    check("tcnt_clr", tick_cnt[15:0], 16'h0);
    check("tcnt_clr_s0", tick_cnt_s0[15:0], 16'h0);
    repeat (3) @(negedge clk);
`endif

    check("sb_drain", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
